// File: rtl/shiftright_iter.sv
// Multi-cycle right shifter: shifts a WIDTH-bit operand right by up to
// STEP positions per clock, logical or arithmetic, with a start/ready
// handshake and a busy flag for ALU stalling.
module shiftright_iter #(
    parameter int WIDTH   = 32,
    parameter int STEP    = 4,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] ctrl_shamt,
    input  logic               ctrl_arith,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               ctrl_busy
);

    localparam int STEP_W = $clog2(STEP + 1);
    localparam logic [SHAMT_W-1:0] STEP_CNT = SHAMT_W'(STEP);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   work, work_next;
    logic [SHAMT_W-1:0] count, count_next;
    logic               fill, fill_next;   // bit shifted into vacated MSBs
    logic [STEP_W-1:0]  step_amt;
    logic [WIDTH-1:0]   shifted;

    // Shared narrow shifter: applies at most STEP positions to the working value.
    always_comb begin
        step_amt = (count >= STEP_CNT) ? STEP_W'(STEP) : count[STEP_W-1:0];
        shifted  = (work >> step_amt)
                 | (fill ? ~({WIDTH{1'b1}} >> step_amt) : '0);
    end

    // Next-state and datapath update.
    always_comb begin
        state_next = state;
        work_next  = work;
        count_next = count;
        fill_next  = fill;
        unique case (state)
            IDLE, DONE: begin
                if (ctrl_start) begin
                    work_next  = data_operand;
                    count_next = ctrl_shamt;
                    fill_next  = ctrl_arith & data_operand[WIDTH-1];
                    state_next = (ctrl_shamt == '0) ? DONE : BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                work_next  = shifted;
                count_next = count - SHAMT_W'(step_amt);
                state_next = (count_next == '0) ? DONE : BUSY;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and working registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            work  <= '0;
            count <= '0;
            fill  <= 1'b0;
        end else begin
            state <= state_next;
            work  <= work_next;
            count <= count_next;
            fill  <= fill_next;
        end
    end

    // Registered outputs, decoded from the state being entered; result only
    // loads on entry to DONE so it holds steady through BUSY and IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            ctrl_busy      <= 1'b0;
        end else begin
            data_resultRDY <= (state_next == DONE);
            ctrl_busy      <= (state_next == BUSY);
            if (state_next == DONE) begin
                data_result <= work_next;
            end
        end
    end

endmodule

// File: tb/tb_shiftright_iter.sv
// Self-checking bench for shiftright_iter: vector table, hand-written
// handshake sequences and randomized operations against a reference model.
module tb_shiftright_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_start;
    logic [31:0] data_operand;
    logic [4:0]  ctrl_shamt;
    logic        ctrl_arith;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        ctrl_busy;

    int checks   = 0;
    int failures = 0;

    shiftright_iter #(.WIDTH(32), .STEP(4), .SHAMT_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .data_operand   (data_operand),
        .ctrl_shamt     (ctrl_shamt),
        .ctrl_arith     (ctrl_arith),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .ctrl_busy      (ctrl_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] op;
        logic [4:0]  sh;
        logic        ar;
        logic [31:0] exp;
        int          exp_busy;
    } vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_shift(input logic [31:0] op, input int sh, input logic ar);
        logic signed [31:0] s;
        logic [31:0] r;
        s = op;
        if (ar) r = s >>> sh;
        else    r = op >> sh;
        return r;
    endfunction

    // Launch from IDLE/DONE, wait for ready, check result, busy count, hold.
    task automatic run_op(input string tag, input logic [31:0] op, input logic [4:0] sh,
                          input logic ar, input logic [31:0] exp, input int exp_busy);
        int busy_n;
        int i;
        logic [31:0] prev;
        logic changed;
        prev = data_result;
        changed = 1'b0;
        ctrl_start = 1'b1; data_operand = op; ctrl_shamt = sh; ctrl_arith = ar;
        tick();
        ctrl_start = 1'b0; data_operand = $urandom; ctrl_shamt = 5'($urandom); ctrl_arith = 1'($urandom);
        busy_n = 0;
        i = 0;
        while (!data_resultRDY && i < 20) begin
            if (ctrl_busy) busy_n++;
            if (data_result !== prev) changed = 1'b1;
            data_operand = $urandom;
            tick();
            i++;
        end
        check({tag, " ready"}, 32'(data_resultRDY), 32'd1);
        check({tag, " result"}, data_result, exp);
        check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_busy));
        check({tag, " result_stable_busy"}, 32'(changed), 32'd0);
        tick();
        check({tag, " ready_pulse"}, 32'(data_resultRDY), 32'd0);
        check({tag, " result_hold"}, data_result, exp);
    endtask

    vec_t vecs[$];

    initial begin
        int n;
        reset = 1'b1; ctrl_start = 1'b1; data_operand = 32'hAAAA5555; ctrl_shamt = 5'd0; ctrl_arith = 1'b0;

        vecs.push_back('{32'hF0F0F0F0, 5'd13, 1'b0, 32'h00078787, 4});
        vecs.push_back('{32'hF0F0F0F0, 5'd13, 1'b1, 32'hFFFF8787, 4});
        vecs.push_back('{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 8});
        vecs.push_back('{32'h80000000, 5'd31, 1'b0, 32'h00000001, 8});
        vecs.push_back('{32'h12345678, 5'd0,  1'b0, 32'h12345678, 0});
        vecs.push_back('{32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000, 8});
        vecs.push_back('{32'h80000000, 5'd1,  1'b1, 32'hC0000000, 1});
        vecs.push_back('{32'hDEADBEEF, 5'd4,  1'b1, 32'hFDEADBEE, 1});
        vecs.push_back('{32'hDEADBEEF, 5'd3,  1'b0, 32'h1BD5B7DD, 1});
        vecs.push_back('{32'hFFFF0000, 5'd16, 1'b0, 32'h0000FFFF, 4});

        // Reset held with start asserted: nothing must be accepted.
        for (int c = 0; c < 5; c++) begin
            tick();
            check("reset result", data_result, 32'h0);
            check("reset ready", 32'(data_resultRDY), 32'd0);
            check("reset busy", 32'(ctrl_busy), 32'd0);
        end
        reset = 1'b0; ctrl_start = 1'b0;
        tick();
        check("post_reset ready", 32'(data_resultRDY), 32'd0);
        check("post_reset busy", 32'(ctrl_busy), 32'd0);

        foreach (vecs[k]) begin
            run_op($sformatf("vec%0d", k), vecs[k].op, vecs[k].sh, vecs[k].ar, vecs[k].exp, vecs[k].exp_busy);
        end

        // Back-to-back: new request accepted during the DONE cycle.
        ctrl_start = 1'b1; data_operand = 32'h12345678; ctrl_shamt = 5'd0; ctrl_arith = 1'b0;
        tick();
        check("b2b first ready", 32'(data_resultRDY), 32'd1);
        check("b2b first result", data_result, 32'h12345678);
        check("b2b first busy", 32'(ctrl_busy), 32'd0);
        data_operand = 32'h00000010; ctrl_shamt = 5'd4;
        tick();
        ctrl_start = 1'b0;
        check("b2b busy", 32'(ctrl_busy), 32'd1);
        check("b2b busy ready", 32'(data_resultRDY), 32'd0);
        check("b2b busy hold", data_result, 32'h12345678);
        tick();
        check("b2b second ready", 32'(data_resultRDY), 32'd1);
        check("b2b second result", data_result, 32'h00000001);
        check("b2b second busy", 32'(ctrl_busy), 32'd0);
        tick();
        check("b2b idle ready", 32'(data_resultRDY), 32'd0);

        // Start pulsed mid-BUSY must be ignored and not queued.
        ctrl_start = 1'b1; data_operand = 32'hFFFF0000; ctrl_shamt = 5'd16; ctrl_arith = 1'b0;
        tick();
        ctrl_start = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !data_resultRDY; i++) begin
            if (ctrl_busy) n++;
            if (n == 2) begin
                ctrl_start = 1'b1; data_operand = 32'h00012345; ctrl_shamt = 5'd1; ctrl_arith = 1'b1;
            end else begin
                ctrl_start = 1'b0;
            end
            tick();
        end
        ctrl_start = 1'b0;
        check("ignore ready", 32'(data_resultRDY), 32'd1);
        check("ignore result", data_result, 32'h0000FFFF);
        check("ignore busy_cycles", 32'(n), 32'd4);
        tick();
        check("ignore no_queue busy", 32'(ctrl_busy), 32'd0);
        check("ignore no_queue ready", 32'(data_resultRDY), 32'd0);

        // Reset at step 2 of a long operation.
        ctrl_start = 1'b1; data_operand = 32'h80000000; ctrl_shamt = 5'd31; ctrl_arith = 1'b1;
        tick();
        ctrl_start = 1'b0;
        tick();
        check("midreset pre busy", 32'(ctrl_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset busy", 32'(ctrl_busy), 32'd0);
        check("midreset ready", 32'(data_resultRDY), 32'd0);
        check("midreset result", data_result, 32'h0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (data_resultRDY || ctrl_busy) n++;
            tick();
        end
        check("midreset discarded", 32'(n), 32'd0);
        run_op("after_reset", 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 8);

        // Randomized operations against the arithmetic model.
        for (int r = 0; r < 150; r++) begin
            logic [31:0] op;
            logic [4:0]  sh;
            logic        ar;
            op = $urandom;
            sh = 5'($urandom_range(0, 31));
            ar = 1'($urandom);
            run_op($sformatf("rand%0d", r), op, sh, ar, model_shift(op, int'(sh), ar), (int'(sh) + 3) / 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shiftright_iter.md
Name: shiftright_iter

Overview:
- Multi-cycle right shifter for the ALU shift path; the right-shift counterpart to the fixed left-shift stages.
- Shifts a 32-bit operand right by a 5-bit amount, up to STEP bit positions per clock, logical or arithmetic.
- The ALU uses a start/ready handshake and stalls on ctrl_busy.
- Trades one shared 4-position datapath for multi-cycle latency instead of a full barrel shifter.

Parameters:
- WIDTH, 32, operand/result width.
- STEP, 4, maximum right-shift positions applied per BUSY cycle.
- SHAMT_W, 5, shift-amount width.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_start  input  1  request; sampled on rising edge.
- data_operand  input  WIDTH  value to shift; sampled with ctrl_start.
- ctrl_shamt  input  SHAMT_W  shift amount 0..31; sampled with ctrl_start.
- ctrl_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- data_result  output  WIDTH  shifted value.
- data_resultRDY  output  1  one-cycle pulse: data_result is valid.
- ctrl_busy  output  1  high while in BUSY.

Behaviour:
- Reset (synchronous, active-high) at any edge, including mid-operation:
  - state returns to IDLE and any in-flight operation is discarded;
  - data_result = 0, data_resultRDY = 0, ctrl_busy = 0, internal count = 0;
  - ctrl_start in the same cycle as reset is ignored.
- States: IDLE, BUSY, DONE. All outputs are registered.
- Accept: ctrl_start=1 at an edge while in IDLE or DONE.
  - Latch operand into the working register, ctrl_shamt into count, ctrl_arith into the mode flag.
  - Go to DONE if ctrl_shamt==0 (working register unchanged), otherwise go to BUSY.
- BUSY, each edge:
  - count>=STEP: working >>= STEP; count -= STEP.
  - 0<count<STEP: working >>= count; count = 0.
  - Vacated MSBs take the latched sign bit (bit WIDTH-1 of the original operand) when arith=1, else 0.
  - If this step leaves count==0, go to DONE; otherwise stay in BUSY.
- ctrl_start while BUSY is ignored. Not queued; operand and shamt inputs don't affect the operation in flight.
- DONE (exactly one cycle):
  - data_resultRDY=1 and data_result = working register.
  - Next state is IDLE, or a new accept if ctrl_start=1 (back-to-back).
- data_result holds its last value after DONE until the next DONE; it does not change during BUSY.
- Latency:
  - Number of BUSY steps k = ceil(shamt/STEP).
  - data_resultRDY is high in the cycle following edge (accept + k).
  - shamt=0 → ready the cycle right after accept. shamt=31 → 8 steps. shamt=13 → steps 4,4,4,1.
- ctrl_busy = 1 exactly in BUSY; it is 0 in IDLE and DONE.
- Widths: count is SHAMT_W bits and never underflows, because the final partial step sets it to 0.
- Shift amounts are always <WIDTH, so there is no modulo behaviour.

Test Plan:
- Reset, then idle: data_result=0x00000000, data_resultRDY=0, ctrl_busy=0 for 5 cycles; ctrl_start asserted with reset high is not accepted.
- Logical shift: operand 0xF0F0F0F0, shamt=13, arith=0 → ctrl_busy high 4 cycles, then data_resultRDY pulses once with data_result=0x00078787, held afterwards.
- Arithmetic shift of the same operand, shamt=13, arith=1 → 0xFFFF8787. Operand 0x80000000, shamt=31: arith=1 → 0xFFFFFFFF; arith=0 → 0x00000001; each after 8 BUSY cycles.
- shamt=0: operand 0x12345678 → ctrl_busy never asserts; data_resultRDY the next cycle with 0x12345678. Back-to-back: ctrl_start held during DONE with shamt=4 on 0x00000010 → next result 0x00000001 after 1 BUSY cycle.
- Start while busy: launch 0xFFFF0000 shamt=16 logical, pulse ctrl_start mid-BUSY with other data → ignored; result 0x0000FFFF after exactly 4 BUSY cycles.
- Reset mid-BUSY at step 2 of a shamt=31 operation → next cycle IDLE, ctrl_busy=0, data_result=0, no data_resultRDY pulse; a fresh request afterwards completes correctly.
